// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer with one-shot / auto-reload modes.
// Software sees CTRL, PRESET and COUNT registers; IRQ is the masked expiry flag.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        enable;
  logic [1:0]  mode;

  assign enable = ctrl_q[0];
  assign mode   = ctrl_q[2:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'b0;
      preset_q   <= 32'b0;
      count_q    <= 32'b0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
          if (mode == 2'd1) irq_flag_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          count_d = preset_q;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Reaching 1 or starting from a zero preset both expire here.
          count_d = 32'b0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        irq_flag_d = 1'b1;
        if (mode != 2'd1) ctrl_d[0] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Software writes are applied last so they win over same-edge FSM updates.
    if (WE) begin
      case (Addr)
        2'd0: begin
          ctrl_d     = Din[3:0];
          irq_flag_d = 1'b0;
        end
        2'd1: begin
          preset_d   = Din;
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (Addr)
      2'd0:    Dout = {28'b0, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = 32'b0;
    endcase
  end

  assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: directed scenarios then random bus traffic,
// each cycle checked against an age-based reference model of the timer.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: a run is tracked by its age r (edges since leaving idle).
  // r=0 loads, r=1..lp counts (COUNT = lp - r afterwards), r=lp+1 raises the flag.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  bit          m_run;
  longint      m_r;
  longint      m_lp;

  task automatic model_step(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d);
    bit         en;
    logic [1:0] mode;
    if (rst) begin
      m_ctrl = 4'b0; m_preset = 32'b0; m_count = 32'b0;
      m_flag = 1'b0; m_run = 1'b0; m_r = 0; m_lp = 1;
      return;
    end
    en   = m_ctrl[0];
    mode = m_ctrl[2:1];
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_r   = 0;
        if (mode == 2'd1) m_flag = 1'b0;
      end
    end else if (m_r == 0) begin
      if (!en) m_run = 1'b0;
      else begin
        m_count = m_preset;
        m_lp    = (m_preset == 0) ? 1 : longint'(m_preset);
        m_r     = 1;
      end
    end else if (m_r <= m_lp) begin
      if (!en) m_run = 1'b0;
      else begin
        m_count = 32'(m_lp - m_r);
        m_r     = m_r + 1;
      end
    end else begin
      m_flag = 1'b1;
      if (mode != 2'd1) m_ctrl[0] = 1'b0;
      m_run = 1'b0;
    end
    if (we && a == 2'd0) begin m_ctrl = d[3:0]; m_flag = 1'b0; end
    if (we && a == 2'd1) begin m_preset = d;    m_flag = 1'b0; end
  endtask

  function automatic exp_t model_out(input logic [1:0] a);
    exp_t e;
    e.addr = a;
    case (a)
      2'd0:    e.dout = {28'b0, m_ctrl};
      2'd1:    e.dout = m_preset;
      2'd2:    e.dout = m_count;
      default: e.dout = 32'b0;
    endcase
    e.irq = m_ctrl[3] & m_flag;
    return e;
  endfunction

  task automatic cyc(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = rst; WE = we; Addr = a; Din = d;
    @(posedge clk);
    model_step(rst, we, a, d);
    exp_q.push_back(model_out(a));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, 32'b0);
  endtask

  // Monitor: every cycle the DUT presents Dout/IRQ, pop and compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      checks++;
      if (Dout !== e.dout || IRQ !== e.irq) begin
        errors++;
        $display("FAIL txn %0d addr %0d: dout=%h irq=%b, expected dout=%h irq=%b",
                 txn, e.addr, Dout, IRQ, e.dout, e.irq);
      end else begin
        $display("txn %0d addr %0d dout=%h irq=%b ok", txn, e.addr, Dout, IRQ);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 2'd0; Din = 32'b0;
    model_step(1'b1, 1'b0, 2'd0, 32'b0);

    // Reset: reads during reset, write blocked by reset.
    cyc(1'b1, 1'b0, 2'd0, 32'b0);
    cyc(1'b1, 1'b0, 2'd1, 32'b0);
    cyc(1'b1, 1'b0, 2'd2, 32'b0);
    cyc(1'b1, 1'b1, 2'd1, 32'h0000_00AB);
    rd(2'd1, 1);

    // One-shot, PRESET=5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2, 8);
    rd(2'd0, 22);
    wr(2'd0, 32'h0);
    rd(2'd0, 2);

    // Auto-reload, PRESET=3, then disable.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd0, 20);
    wr(2'd0, 32'hA);
    rd(2'd2, 10);

    // Masked interrupt.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    rd(2'd0, 8);
    wr(2'd0, 32'h8);
    rd(2'd0, 3);

    // Mid-count PRESET change in auto-reload mode.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    rd(2'd2, 6);
    wr(2'd1, 32'd2);
    rd(2'd2, 30);

    // PRESET=0, write to read-only COUNT, reset mid-count.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd0, 6);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 2);
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    rd(2'd2, 6);
    cyc(1'b1, 1'b0, 2'd2, 32'b0);
    rd(2'd2, 3);

    // Random traffic with small presets so expiries happen often.
    for (int i = 0; i < 1000; i++) begin
      bit          r;
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 9) == 0);
      a = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 6));
      if (w && a == 2'd0) d = {$urandom_range(0, 255), 4'($urandom_range(0, 15))} | 32'h1;
      cyc(r, w, a, d);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
